cpu_core: RTL and testbench

CPU_CORE -- requirements
Module: cpu_core

---
 rtl/cpu_core_pkg.sv | 59 +++++
 rtl/cpu_core_alu.sv | 61 ++++++
 rtl/cpu_core.sv | 224 ++++++++++++++++++++++
 tb/tb_cpu_core.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_core_pkg.sv
// cpu_core_pkg: shared types for the 8-bit accumulator-style CPU core.
// Opcode and FSM state enums, JCC condition codes, flag bit positions,
// register-file sizing and a flag helper used by the load-type instructions.
package cpu_core_pkg;

    localparam int unsigned REG_IDX_W = 2;
    localparam int unsigned NUM_REGS  = 4;

    // FLAGS bus layout is {N, C, Z}
    localparam int unsigned FLAG_Z = 0;
    localparam int unsigned FLAG_C = 1;
    localparam int unsigned FLAG_N = 2;

    typedef enum logic [3:0] {
        OP_NOP  = 4'h0,
        OP_MOV  = 4'h1,
        OP_LDI  = 4'h2,
        OP_ADD  = 4'h3,
        OP_ADC  = 4'h4,
        OP_SUB  = 4'h5,
        OP_AND  = 4'h6,
        OP_OR   = 4'h7,
        OP_XOR  = 4'h8,
        OP_LD   = 4'h9,
        OP_ST   = 4'hA,
        OP_JCC  = 4'hB,
        OP_RSVC = 4'hC,
        OP_RSVD = 4'hD,
        OP_RSVE = 4'hE,
        OP_HLT  = 4'hF
    } opcode_e;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_OPND0  = 3'd1,
        ST_OPND1  = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_HALTED = 3'd5
    } state_e;

    typedef enum logic [1:0] {
        COND_ALWAYS = 2'b00,
        COND_Z      = 2'b01,
        COND_C      = 2'b10,
        COND_N      = 2'b11
    } cond_e;

    // Flags after MOV/LDI/LD: Z and N from the value, carry passed through
    function automatic logic [2:0] load_flags(input logic [7:0] value, input logic carry);
        return {value[7], carry, (value == 8'h00)};
    endfunction

    // Opcodes followed by at least one operand byte
    function automatic logic needs_operand(input opcode_e op);
        return (op == OP_LDI) || (op == OP_LD) || (op == OP_ST) || (op == OP_JCC);
    endfunction

endpackage

// File: rtl/cpu_core_alu.sv
// cpu_core_alu: purely combinational 8-bit ALU for ADD/ADC/SUB/AND/OR/XOR.
// SUB reports C=1 when no borrow occurred; logic ops clear C.
module cpu_core_alu
    import cpu_core_pkg::*;
(
    input  logic [7:0] lhs,
    input  logic [7:0] rhs,
    input  opcode_e    op,
    input  logic       carry_in,
    output logic [7:0] result,
    output logic       C,
    output logic       Z,
    output logic       N
);

    logic [8:0] sum9_s;

    // Compute result and carry for the selected operation
    always_comb begin
        sum9_s = 9'h000;
        result = lhs;
        C      = carry_in;
        case (op)
            OP_ADD: begin
                sum9_s = {1'b0, lhs} + {1'b0, rhs};
                result = sum9_s[7:0];
                C      = sum9_s[8];
            end
            OP_ADC: begin
                sum9_s = {1'b0, lhs} + {1'b0, rhs} + {8'h00, carry_in};
                result = sum9_s[7:0];
                C      = sum9_s[8];
            end
            OP_SUB: begin
                sum9_s = {1'b0, lhs} - {1'b0, rhs};
                result = sum9_s[7:0];
                C      = ~sum9_s[8];
            end
            OP_AND: begin
                result = lhs & rhs;
                C      = 1'b0;
            end
            OP_OR: begin
                result = lhs | rhs;
                C      = 1'b0;
            end
            OP_XOR: begin
                result = lhs ^ rhs;
                C      = 1'b0;
            end
            default: begin
                result = lhs;
                C      = carry_in;
            end
        endcase
    end

    assign Z = (result == 8'h00);
    assign N = result[7];

endmodule

// File: rtl/cpu_core.sv
// cpu_core: multi-cycle 8-bit CPU with a 4-entry register file.
// Instruction byte = {op[7:4], dst[3:2], src[1:0]}; operands follow the opcode.
// Optional macro CPU_CORE_WAIT_EN adds MEM_READY: any fetch, operand or MEM
// cycle without ready holds all state and memory outputs.
module cpu_core
    import cpu_core_pkg::*;
#(
    parameter int unsigned           ADDR_WIDTH   = 16,
    parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = {ADDR_WIDTH{1'b0}}
) (
    input  logic                  CLK,
    input  logic                  RST,
    output logic [ADDR_WIDTH-1:0] MEM_ADDR,
    input  logic [7:0]            MEM_RDATA,
    output logic [7:0]            MEM_WDATA,
    output logic                  MEM_WE,
`ifdef CPU_CORE_WAIT_EN
    input  logic                  MEM_READY,
`endif
    output logic                  HALT,
    output logic [2:0]            FLAGS,
    output logic [ADDR_WIDTH-1:0] PC_OUT
);

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   pc_q, pc_d, pc_inc_s;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [ADDR_WIDTH-1:0]   mem_addr_q, mem_addr_d;
    logic [7:0]              ir_q, ir_d, opnd_q, opnd_d;
    logic [7:0]              mem_wdata_q, mem_wdata_d;
    logic                    mem_we_q, mem_we_d, halt_q, halt_d;
    logic [2:0]              flags_q, flags_d;
    logic [7:0]              regs_q [NUM_REGS];
    logic [7:0]              regs_d [NUM_REGS];
    logic                    ready_s, jcc_taken_s;
    logic [15:0]             full_addr_s;
    opcode_e                 op_s, fetch_op_s;
    logic [REG_IDX_W-1:0]    dst_s, src_s;
    logic [7:0]              alu_result_s;
    logic                    alu_c_s, alu_z_s, alu_n_s;

`ifdef CPU_CORE_WAIT_EN
    assign ready_s = MEM_READY;
`else
    assign ready_s = 1'b1;
`endif

    assign op_s        = opcode_e'(ir_q[7:4]);
    assign dst_s       = ir_q[3:2];
    assign src_s       = ir_q[1:0];
    assign fetch_op_s  = opcode_e'(MEM_RDATA[7:4]);
    assign pc_inc_s    = pc_q + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
    assign full_addr_s = {MEM_RDATA, opnd_q};

    cpu_core_alu u_alu (
        .lhs      (regs_q[dst_s]),
        .rhs      (regs_q[src_s]),
        .op       (op_s),
        .carry_in (flags_q[FLAG_C]),
        .result   (alu_result_s),
        .C        (alu_c_s),
        .Z        (alu_z_s),
        .N        (alu_n_s)
    );

    // FSM state register
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= ST_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state: operand count decides the path, waits hold the state
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_FETCH: begin
                if (!ready_s)                       state_d = ST_FETCH;
                else if (needs_operand(fetch_op_s)) state_d = ST_OPND0;
                else                                state_d = ST_EXEC;
            end
            ST_OPND0: begin
                if (!ready_s)              state_d = ST_OPND0;
                else if (op_s == OP_LDI)   state_d = ST_EXEC;
                else                       state_d = ST_OPND1;
            end
            ST_OPND1: begin
                if (!ready_s)              state_d = ST_OPND1;
                else if (op_s == OP_JCC)   state_d = ST_EXEC;
                else                       state_d = ST_MEM;
            end
            ST_EXEC: begin
                if (op_s == OP_HLT) state_d = ST_HALTED;
                else                state_d = ST_FETCH;
            end
            ST_MEM: begin
                if (ready_s) state_d = ST_FETCH;
                else         state_d = ST_MEM;
            end
            ST_HALTED: state_d = ST_HALTED;
            default:   state_d = ST_FETCH;
        endcase
    end

    // Evaluate the JCC condition held in the dst field
    always_comb begin
        case (cond_e'(dst_s))
            COND_ALWAYS: jcc_taken_s = 1'b1;
            COND_Z:      jcc_taken_s = flags_q[FLAG_Z];
            COND_C:      jcc_taken_s = flags_q[FLAG_C];
            COND_N:      jcc_taken_s = flags_q[FLAG_N];
            default:     jcc_taken_s = 1'b0;
        endcase
    end

    // Datapath next values and registered memory-interface outputs
    always_comb begin
        pc_d    = pc_q;
        ir_d    = ir_q;
        opnd_d  = opnd_q;
        addr_d  = addr_q;
        regs_d  = regs_q;
        flags_d = flags_q;
        case (state_q)
            ST_FETCH: begin
                if (ready_s) begin
                    ir_d = MEM_RDATA;
                    pc_d = pc_inc_s;
                end else begin
                    ir_d = ir_q;
                end
            end
            ST_OPND0: begin
                if (ready_s) begin
                    opnd_d = MEM_RDATA;
                    pc_d   = pc_inc_s;
                end else begin
                    opnd_d = opnd_q;
                end
            end
            ST_OPND1: begin
                if (ready_s) begin
                    addr_d = full_addr_s[ADDR_WIDTH-1:0];
                    pc_d   = pc_inc_s;
                end else begin
                    addr_d = addr_q;
                end
            end
            ST_EXEC: begin
                case (op_s)
                    OP_MOV: begin
                        regs_d[dst_s] = regs_q[src_s];
                        flags_d       = load_flags(regs_q[src_s], flags_q[FLAG_C]);
                    end
                    OP_LDI: begin
                        regs_d[dst_s] = opnd_q;
                        flags_d       = load_flags(opnd_q, flags_q[FLAG_C]);
                    end
                    OP_ADD, OP_ADC, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
                        regs_d[dst_s] = alu_result_s;
                        flags_d       = {alu_n_s, alu_c_s, alu_z_s};
                    end
                    OP_JCC: begin
                        if (jcc_taken_s) pc_d = addr_q;
                        else             pc_d = pc_q;
                    end
                    default: flags_d = flags_q;
                endcase
            end
            ST_MEM: begin
                if (ready_s && (op_s == OP_LD)) begin
                    regs_d[dst_s] = MEM_RDATA;
                    flags_d       = load_flags(MEM_RDATA, flags_q[FLAG_C]);
                end else begin
                    flags_d = flags_q;
                end
            end
            default: pc_d = pc_q;
        endcase

        // The bus shows the operand address only while in MEM, else the PC
        mem_addr_d  = (state_d == ST_MEM) ? addr_d : pc_d;
        mem_we_d    = (state_d == ST_MEM) && (op_s == OP_ST);
        mem_wdata_d = mem_we_d ? regs_q[src_s] : 8'h00;
        halt_d      = (state_d == ST_HALTED);
    end

    // Datapath and output registers; reset aborts any instruction at once
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            pc_q        <= RESET_VECTOR;
            ir_q        <= 8'h00;
            opnd_q      <= 8'h00;
            addr_q      <= {ADDR_WIDTH{1'b0}};
            regs_q      <= '{default: 8'h00};
            flags_q     <= 3'b000;
            mem_addr_q  <= RESET_VECTOR;
            mem_we_q    <= 1'b0;
            mem_wdata_q <= 8'h00;
            halt_q      <= 1'b0;
        end else begin
            pc_q        <= pc_d;
            ir_q        <= ir_d;
            opnd_q      <= opnd_d;
            addr_q      <= addr_d;
            regs_q      <= regs_d;
            flags_q     <= flags_d;
            mem_addr_q  <= mem_addr_d;
            mem_we_q    <= mem_we_d;
            mem_wdata_q <= mem_wdata_d;
            halt_q      <= halt_d;
        end
    end

    assign MEM_ADDR  = mem_addr_q;
    assign MEM_WE    = mem_we_q;
    assign MEM_WDATA = mem_wdata_q;
    assign HALT      = halt_q;
    assign FLAGS     = flags_q;
    assign PC_OUT    = pc_q;

endmodule

// File: tb/tb_cpu_core.sv
// tb_cpu_core: directed, self-checking bench for cpu_core.
// A 16-bit-address core runs small hand-assembled programs from a bench
// memory; an 8-bit-address core with RESET_VECTOR=0xFE checks PC wrap.
module tb_cpu_core;

    logic        CLK, RST, RST2, mem_ready;
    logic [15:0] MEM_ADDR, PC_OUT;
    logic [7:0]  MEM_RDATA, MEM_WDATA;
    logic        MEM_WE, HALT;
    logic [2:0]  FLAGS;
    logic [7:0]  mem_addr2, pc2, rdata2, wdata2;
    logic        we2, halt2;
    logic [2:0]  flags2;
    logic [7:0]  mem  [65536];
    logic [7:0]  mem2 [256];
    int          n_cmp, n_bad;

    assign MEM_RDATA = mem[MEM_ADDR];
    assign rdata2    = mem2[mem_addr2];

    cpu_core #(.ADDR_WIDTH(16), .RESET_VECTOR(16'h0000)) dut (
        .CLK(CLK), .RST(RST), .MEM_ADDR(MEM_ADDR), .MEM_RDATA(MEM_RDATA),
        .MEM_WDATA(MEM_WDATA), .MEM_WE(MEM_WE),
`ifdef CPU_CORE_WAIT_EN
        .MEM_READY(mem_ready),
`endif
        .HALT(HALT), .FLAGS(FLAGS), .PC_OUT(PC_OUT)
    );

    cpu_core #(.ADDR_WIDTH(8), .RESET_VECTOR(8'hFE)) dut8 (
        .CLK(CLK), .RST(RST2), .MEM_ADDR(mem_addr2), .MEM_RDATA(rdata2),
        .MEM_WDATA(wdata2), .MEM_WE(we2),
`ifdef CPU_CORE_WAIT_EN
        .MEM_READY(1'b1),
`endif
        .HALT(halt2), .FLAGS(flags2), .PC_OUT(pc2)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Bench memory: store on the rising edge when the core writes and is ready
    always @(posedge CLK) begin
        if (MEM_WE && mem_ready) mem[MEM_ADDR] = MEM_WDATA;
    end

    task automatic step(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
        for (int i = 0; i < 256; i++) mem2[i] = 8'h00;
    endtask

    task automatic start();
        @(negedge CLK);
        RST = 1'b0;
    endtask

    task automatic test_reset();
        RST = 1'b1; RST2 = 1'b1; mem_ready = 1'b1;
        clear_mem();
        step(2);
        n_cmp++; if (PC_OUT !== 16'h0000) begin n_bad++; $display("FAIL rst_pc: got %h expected 0000", PC_OUT); end
        n_cmp++; if (MEM_ADDR !== 16'h0000) begin n_bad++; $display("FAIL rst_addr: got %h expected 0000", MEM_ADDR); end
        n_cmp++; if (MEM_WE !== 1'b0) begin n_bad++; $display("FAIL rst_we: got %b expected 0", MEM_WE); end
        n_cmp++; if (MEM_WDATA !== 8'h00) begin n_bad++; $display("FAIL rst_wdata: got %h expected 00", MEM_WDATA); end
        n_cmp++; if (HALT !== 1'b0) begin n_bad++; $display("FAIL rst_halt: got %b expected 0", HALT); end
        n_cmp++; if (FLAGS !== 3'b000) begin n_bad++; $display("FAIL rst_flags: got %b expected 000", FLAGS); end
        n_cmp++; if (pc2 !== 8'hFE) begin n_bad++; $display("FAIL rst_pc8: got %h expected fe", pc2); end
        n_cmp++; if (mem_addr2 !== 8'hFE) begin n_bad++; $display("FAIL rst_addr8: got %h expected fe", mem_addr2); end
    endtask

    task automatic test_add_overflow();
        // LDI A,#7F; LDI B,#1; ADD A,B; HLT
        RST = 1'b1; clear_mem();
        mem[0] = 8'h20; mem[1] = 8'h7F; mem[2] = 8'h24; mem[3] = 8'h01; mem[4] = 8'h31; mem[5] = 8'hF0;
        start();
        step(8);
        n_cmp++; if (FLAGS !== 3'b100) begin n_bad++; $display("FAIL add_flags: got %b expected 100", FLAGS); end
        step(1);
        n_cmp++; if (HALT !== 1'b0) begin n_bad++; $display("FAIL halt_early: got %b expected 0", HALT); end
        step(1);
        n_cmp++; if (HALT !== 1'b1) begin n_bad++; $display("FAIL halt_at10: got %b expected 1", HALT); end
        step(3);
        n_cmp++; if (PC_OUT !== 16'h0006) begin n_bad++; $display("FAIL halt_pc: got %h expected 0006", PC_OUT); end
        n_cmp++; if (HALT !== 1'b1 || FLAGS !== 3'b100) begin n_bad++; $display("FAIL halt_hold: got %b/%b expected 1/100", HALT, FLAGS); end
        // Same computation with ST A,[0x0100] before HLT to expose A
        RST = 1'b1; clear_mem();
        mem[0] = 8'h20; mem[1] = 8'h7F; mem[2] = 8'h24; mem[3] = 8'h01; mem[4] = 8'h31;
        mem[5] = 8'hA0; mem[6] = 8'h00; mem[7] = 8'h01; mem[8] = 8'hF0; mem[16'h0100] = 8'hEE;
        start();
        step(14);
        n_cmp++; if (mem[16'h0100] !== 8'h80) begin n_bad++; $display("FAIL add_result: got %h expected 80", mem[16'h0100]); end
    endtask

    task automatic test_jcc();
        // LDI A,#FF; LDI B,#1; ADD A,B; JCC C,0x0010 ; at 0x10: ST A,[0x0200]; HLT
        RST = 1'b1; clear_mem();
        mem[0] = 8'h20; mem[1] = 8'hFF; mem[2] = 8'h24; mem[3] = 8'h01; mem[4] = 8'h31;
        mem[5] = 8'hB8; mem[6] = 8'h10; mem[7] = 8'h00;
        mem[16'h10] = 8'hA0; mem[16'h11] = 8'h00; mem[16'h12] = 8'h02; mem[16'h13] = 8'hF0; mem[16'h0200] = 8'hEE;
        start();
        step(8);
        n_cmp++; if (FLAGS !== 3'b011) begin n_bad++; $display("FAIL carry_flags: got %b expected 011", FLAGS); end
        step(4);
        n_cmp++; if (PC_OUT !== 16'h0010) begin n_bad++; $display("FAIL jcc_taken_pc: got %h expected 0010", PC_OUT); end
        n_cmp++; if (MEM_ADDR !== 16'h0010) begin n_bad++; $display("FAIL jcc_taken_addr: got %h expected 0010", MEM_ADDR); end
        step(6);
        n_cmp++; if (mem[16'h0200] !== 8'h00) begin n_bad++; $display("FAIL carry_result: got %h expected 00", mem[16'h0200]); end
        // NOP; NOP; same sequence with JCC N -> not taken, PC past the JCC = 0x000A
        RST = 1'b1; clear_mem();
        mem[0] = 8'h00; mem[1] = 8'h00; mem[2] = 8'h20; mem[3] = 8'hFF; mem[4] = 8'h24; mem[5] = 8'h01;
        mem[6] = 8'h31; mem[7] = 8'hBC; mem[8] = 8'h10; mem[9] = 8'h00; mem[10] = 8'hF0; mem[16'h10] = 8'hF0;
        start();
        step(16);
        n_cmp++; if (PC_OUT !== 16'h000A) begin n_bad++; $display("FAIL jcc_not_taken_pc: got %h expected 000a", PC_OUT); end
        n_cmp++; if (FLAGS !== 3'b011) begin n_bad++; $display("FAIL jcc_flags_kept: got %b expected 011", FLAGS); end
    endtask

    task automatic test_alu_ops();
        logic [2:0] exp_f [7];
        // LDI A,0F; LDI B,F0; SUB A,B; ADC A,B; MOV C,A; XOR A,B; AND A,C; SUB A,A; ADC A,B;
        // ST C,[0100]; ST A,[0101]; HLT
        exp_f = '{3'b000, 3'b010, 3'b010, 3'b100, 3'b000, 3'b011, 3'b100};
        RST = 1'b1; clear_mem();
        mem[0] = 8'h20; mem[1] = 8'h0F; mem[2] = 8'h24; mem[3] = 8'hF0; mem[4] = 8'h51; mem[5] = 8'h41;
        mem[6] = 8'h18; mem[7] = 8'h81; mem[8] = 8'h62; mem[9] = 8'h50; mem[10] = 8'h41;
        mem[11] = 8'hA2; mem[12] = 8'h00; mem[13] = 8'h01; mem[14] = 8'hA0; mem[15] = 8'h01; mem[16] = 8'h01;
        mem[17] = 8'hF0; mem[16'h0100] = 8'hEE; mem[16'h0101] = 8'hEE;
        start();
        step(6);
        for (int i = 0; i < 7; i++) begin
            step(2);
            n_cmp++; if (FLAGS !== exp_f[i]) begin n_bad++; $display("FAIL alu_flags[%0d]: got %b expected %b", i, FLAGS, exp_f[i]); end
        end
        step(10);
        n_cmp++; if (mem[16'h0100] !== 8'h0F) begin n_bad++; $display("FAIL mov_result: got %h expected 0f", mem[16'h0100]); end
        n_cmp++; if (mem[16'h0101] !== 8'hF1) begin n_bad++; $display("FAIL adc_carry_in: got %h expected f1", mem[16'h0101]); end
        n_cmp++; if (HALT !== 1'b1) begin n_bad++; $display("FAIL alu_halt: got %b expected 1", HALT); end
    endtask

    task automatic test_store_load();
        int we_8000, we_9000, we_total;
        // LDI C,#5A; ST [8000],C; LD D,[8000]; ST [9000],D; HLT
        RST = 1'b1; clear_mem();
        mem[0] = 8'h28; mem[1] = 8'h5A; mem[2] = 8'hA2; mem[3] = 8'h00; mem[4] = 8'h80;
        mem[5] = 8'h9C; mem[6] = 8'h00; mem[7] = 8'h80; mem[8] = 8'hA3; mem[9] = 8'h00; mem[10] = 8'h90;
        mem[11] = 8'hF0; mem[16'h9000] = 8'hEE;
        we_8000 = 0; we_9000 = 0; we_total = 0;
        start();
        for (int k = 1; k <= 20; k++) begin
            step(1);
            if (MEM_WE === 1'b1) begin
                we_total++;
                if (MEM_ADDR === 16'h8000) we_8000++;
                if (MEM_ADDR === 16'h9000) we_9000++;
            end
            if (k == 6) begin
                n_cmp++; if (MEM_WE !== 1'b1 || MEM_ADDR !== 16'h8000 || MEM_WDATA !== 8'h5A) begin
                    n_bad++; $display("FAIL st_bus: got we=%b addr=%h wdata=%h expected 1/8000/5a", MEM_WE, MEM_ADDR, MEM_WDATA);
                end
            end
            if (k == 7) begin
                n_cmp++; if (MEM_WE !== 1'b0 || MEM_ADDR !== 16'h0005) begin
                    n_bad++; $display("FAIL st_end: got we=%b addr=%h expected 0/0005", MEM_WE, MEM_ADDR);
                end
            end
        end
        n_cmp++; if (we_8000 !== 1) begin n_bad++; $display("FAIL st_pulse_count: got %0d expected 1", we_8000); end
        n_cmp++; if (we_total !== 2 || we_9000 !== 1) begin n_bad++; $display("FAIL we_total: got %0d/%0d expected 2/1", we_total, we_9000); end
        n_cmp++; if (mem[16'h8000] !== 8'h5A) begin n_bad++; $display("FAIL st_data: got %h expected 5a", mem[16'h8000]); end
        n_cmp++; if (mem[16'h9000] !== 8'h5A) begin n_bad++; $display("FAIL ld_data: got %h expected 5a", mem[16'h9000]); end
    endtask

    task automatic test_pc_wrap();
        @(negedge CLK);
        RST2 = 1'b0;
        #1;
        n_cmp++; if (mem_addr2 !== 8'hFE) begin n_bad++; $display("FAIL wrap_fetch1: got %h expected fe", mem_addr2); end
        step(2);
        n_cmp++; if (mem_addr2 !== 8'hFF) begin n_bad++; $display("FAIL wrap_fetch2: got %h expected ff", mem_addr2); end
        step(2);
        n_cmp++; if (mem_addr2 !== 8'h00 || pc2 !== 8'h00) begin n_bad++; $display("FAIL wrap_fetch3: got %h/%h expected 00/00", mem_addr2, pc2); end
        n_cmp++; if (we2 !== 1'b0 || halt2 !== 1'b0 || flags2 !== 3'b000 || wdata2 !== 8'h00) begin
            n_bad++; $display("FAIL wrap_quiet: got we=%b halt=%b flags=%b wdata=%h", we2, halt2, flags2, wdata2);
        end
    endtask

    task automatic test_reset_during_store();
        RST = 1'b1; clear_mem();
        mem[0] = 8'h28; mem[1] = 8'h5A; mem[2] = 8'hA2; mem[3] = 8'h00; mem[4] = 8'h80; mem[16'h8000] = 8'h33;
        start();
        step(6);
        n_cmp++; if (MEM_WE !== 1'b1) begin n_bad++; $display("FAIL pre_abort_we: got %b expected 1", MEM_WE); end
        #2 RST = 1'b1;
        #1;
        n_cmp++; if (MEM_WE !== 1'b0) begin n_bad++; $display("FAIL abort_we: got %b expected 0", MEM_WE); end
        n_cmp++; if (PC_OUT !== 16'h0000 || MEM_ADDR !== 16'h0000 || FLAGS !== 3'b000) begin
            n_bad++; $display("FAIL abort_state: got pc=%h addr=%h flags=%b expected 0000/0000/000", PC_OUT, MEM_ADDR, FLAGS);
        end
        // ST C,[0200]; HLT -- C must read back as zero after the abort
        mem[0] = 8'hA2; mem[1] = 8'h00; mem[2] = 8'h02; mem[3] = 8'hF0; mem[16'h0200] = 8'hEE;
        start();
        step(1);
        n_cmp++; if (PC_OUT !== 16'h0001) begin n_bad++; $display("FAIL abort_refetch: got %h expected 0001", PC_OUT); end
        step(5);
        n_cmp++; if (mem[16'h0200] !== 8'h00) begin n_bad++; $display("FAIL abort_regs: got %h expected 00", mem[16'h0200]); end
        n_cmp++; if (mem[16'h8000] !== 8'h33) begin n_bad++; $display("FAIL abort_no_write: got %h expected 33", mem[16'h8000]); end
    endtask

`ifdef CPU_CORE_WAIT_EN
    task automatic test_wait_store();
        // LDI C,#5A; ST [8000],C; HLT with 3 wait cycles in the MEM cycle
        RST = 1'b1; clear_mem();
        mem[0] = 8'h28; mem[1] = 8'h5A; mem[2] = 8'hA2; mem[3] = 8'h00; mem[4] = 8'h80; mem[5] = 8'hF0;
        start();
        step(6);
        mem_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            n_cmp++; if (MEM_WE !== 1'b1 || PC_OUT !== 16'h0005 || MEM_ADDR !== 16'h8000) begin
                n_bad++; $display("FAIL wait_hold[%0d]: got we=%b pc=%h addr=%h", k, MEM_WE, PC_OUT, MEM_ADDR);
            end
            step(1);
        end
        n_cmp++; if (MEM_WE !== 1'b1 || PC_OUT !== 16'h0005) begin n_bad++; $display("FAIL wait_last: got we=%b pc=%h", MEM_WE, PC_OUT); end
        mem_ready = 1'b1;
        step(1);
        n_cmp++; if (MEM_WE !== 1'b0 || mem[16'h8000] !== 8'h5A) begin
            n_bad++; $display("FAIL wait_release: got we=%b data=%h expected 0/5a", MEM_WE, mem[16'h8000]);
        end
    endtask
`endif

    initial begin
        n_cmp = 0; n_bad = 0;
        RST = 1'b1; RST2 = 1'b1; mem_ready = 1'b1;
        test_reset();
        test_add_overflow();
        test_jcc();
        test_alu_ops();
        test_store_load();
        test_pc_wrap();
        test_reset_during_store();
`ifdef CPU_CORE_WAIT_EN
        test_wait_store();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
